uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver, the receive-side counterpart of `uart_tx`, for the picorv32 SoC. Oversamples `rx_pin` on the CPU clock, decodes 8N1 frames (LSB first), and presents received bytes on a valid/ready interface for the SoC UART register decoder. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `UART_CLK_HZ`, 27000000, input clock frequency.
- `BAUD_RATE`, 115200, line rate.
- `FIFO_DEPTH_LOG2`, 3, log2 of the receive FIFO depth. Used only when `UART_RX_FIFO_EN` is defined.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_pin`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  head byte; reset 0.
- `rx_data_valid`  out  1  a byte is available; reset 0.
- `rx_data_ready`  in  1  the consumer pops the head byte when it is high together with `rx_data_valid`.
- `frame_error`  out  1  one-cycle pulse when a stop bit is read as 0; reset 0.
- `overrun`  out  1  one-cycle pulse when a received byte is dropped because storage is full; reset 0.

## Operation
- Derived constants:
  - `CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE` (integer division).
  - `HALF_BIT = CLKS_PER_BIT / 2`.
  - The bit counter width is `$clog2(CLKS_PER_BIT)`.
- Synchronizer:
  - `rx_pin` passes through a 2-FF synchronizer, both FFs reset to 1.
  - All logic uses the synchronized value `rx_s`.
- State machine (reset state IDLE):
  - IDLE: when `rx_s` == 0, go to START and clear the counter.
  - START: when the counter reaches `HALF_BIT-1`, sample `rx_s`.
    - 0: go to DATA, clear the counter and the bit index.
    - 1: glitch; go back to IDLE with no error.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` and shift it into bit 7 of the shift register (right shift, so the result is LSB-first).
    - After 8 samples, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - 1: push the byte and go to IDLE.
    - 0: pulse `frame_error`, discard the byte, go to BREAK.
  - BREAK: wait until `rx_s` == 1, then go to IDLE. This prevents a held-low line from being seen as repeated frames.
- Storage:
  - A push when storage is full drops the new byte and pulses `overrun`; stored contents are unchanged.
  - Push and pop in the same cycle while full: the pop happens first, the push is accepted and there is no overrun.
- `rx_data` is stable while `rx_data_valid` is high and not yet popped.
- Reset mid-frame: the FSM returns to IDLE, storage is emptied, and all outputs go to their reset values on the asynchronous assert.

## Timing
- The start edge is detected in IDLE 2 cycles after the `rx_pin` fall, because of the synchronizer.
- Data bit n (0..7) is sampled `HALF_BIT + (n+1)*CLKS_PER_BIT` cycles after START entry.
- The stop bit is sampled `HALF_BIT + 9*CLKS_PER_BIT` cycles after START entry.
- The push happens in the stop-sample cycle. `rx_data_valid` and `rx_data` update on the next rising edge, giving 1-cycle latency.
- The pop happens on the edge where `rx_data_valid && rx_data_ready`.
  - The next byte, if present, is on `rx_data` the cycle after that edge.
  - Otherwise `rx_data_valid` drops that cycle.
- `frame_error` and `overrun` are registered pulses, high for exactly the cycle after the stop sample.
- Back-to-back frames are supported: IDLE is re-entered mid-stop-bit, so a start bit directly after the stop bit is detected.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - Storage is a circular FIFO of `2**FIFO_DEPTH_LOG2` bytes.
  - Read and write pointers are `FIFO_DEPTH_LOG2+1` bits wide.
  - Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal; pointers wrap naturally.
  - `rx_data` is the entry at the read pointer.
- `UART_RX_FIFO_EN` undefined:
  - Storage is a single holding register plus a valid flag (depth 1).
  - `FIFO_DEPTH_LOG2` is ignored.
  - A second byte arriving while `rx_data_valid` is high and not popped in that cycle causes `overrun`.

## Test plan
All scenarios use `UART_CLK_HZ=1000000` and `BAUD_RATE=100000`, giving `CLKS_PER_BIT=10` and `HALF_BIT=5`.
- Single byte: drive frame 0xA5 with a valid stop bit and `rx_data_ready=0` -> `rx_data_valid`=1, `rx_data`=0xA5, no pulses. Pulse ready for 1 cycle -> `rx_data_valid`=0.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap, consumer always ready -> three pops in order 0x00, 0xFF, 0x3C.
- Glitch: 3-cycle low pulse on `rx_pin` -> no byte and no `frame_error`; FSM back in IDLE. A following frame 0x55 is then received correctly.
- Framing error: send frame 0x81 with stop bit 0, then hold the line low for 30 cycles -> exactly one `frame_error` pulse and no byte. A frame sent after the line returns high is received.
- Overrun, FIFO build (depth 8), ready=0: send 9 bytes 0x01..0x09 -> one `overrun` pulse on byte 9. Popping returns 0x01..0x08.
- Overrun, non-FIFO build, ready=0: send 0x11 then 0x22 -> one `overrun` pulse and `rx_data`=0x11.
- Reset mid-frame: assert `rst_n`=0 during the DATA state -> all outputs 0 immediately. After release, frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle between uart_rx and the SoC UART register decoder.
// master = the receiver producing bytes and pulses, slave = the consumer popping them.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       frame_error;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_data_valid,
    output frame_error,
    output overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  frame_error,
    input  overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with valid/ready byte output and error pulses.
// Define UART_RX_FIFO_EN for a 2**FIFO_DEPTH_LOG2 byte FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int UART_CLK_HZ     = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_pin,
  uart_rx_if.master rx
);
  localparam int CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

  // Elaboration-time guard against configurations the counters cannot represent.
  if (CLKS_PER_BIT < 4 || FIFO_DEPTH_LOG2 < 1) begin : g_bad_cfg
    $error("uart_rx: unsupported CLKS_PER_BIT or FIFO_DEPTH_LOG2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             sync_reg, rx_s;
  logic             push, stop_bad, pop, accept;
  logic             frame_error_reg, overrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      sync_reg <= rx_pin;
      rx_s     <= sync_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt_reg == CNT_HALF_END) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_BIT_END) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        // Leaving mid-stop-bit lets a start bit directly after it be caught.
        if (cnt_reg == CNT_BIT_END) begin
          cnt_next = '0;
          if (rx_s) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BRK;
          end
        end
      end
      BRK: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_error_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      frame_error_reg <= stop_bad;
      overrun_reg     <= push && !accept;
    end
  end

  assign rx.frame_error = frame_error_reg;
  assign rx.overrun     = overrun_reg;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

  logic [7:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wptr_reg, rptr_reg;
  logic                     empty, full;

  assign empty  = (wptr_reg == rptr_reg);
  assign full   = (wptr_reg[FIFO_DEPTH_LOG2] != rptr_reg[FIFO_DEPTH_LOG2]) &&
                  (wptr_reg[FIFO_DEPTH_LOG2-1:0] == rptr_reg[FIFO_DEPTH_LOG2-1:0]);
  assign pop    = !empty && rx.rx_data_ready;
  // A simultaneous pop frees the slot the push needs.
  assign accept = !full || pop;

  always_ff @(posedge clk) begin
    if (push && accept) mem[wptr_reg[FIFO_DEPTH_LOG2-1:0]] <= shift_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push && accept) wptr_reg <= wptr_reg + 1'b1;
      if (pop)            rptr_reg <= rptr_reg + 1'b1;
    end
  end

  assign rx.rx_data       = empty ? 8'h00 : mem[rptr_reg[FIFO_DEPTH_LOG2-1:0]];
  assign rx.rx_data_valid = !empty;
`else
  logic [7:0] hold_reg;
  logic       hold_valid_reg;

  assign pop    = hold_valid_reg && rx.rx_data_ready;
  assign accept = !hold_valid_reg || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg       <= 8'h00;
      hold_valid_reg <= 1'b0;
    end else if (push && accept) begin
      hold_reg       <= shift_reg;
      hold_valid_reg <= 1'b1;
    end else if (pop) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign rx.rx_data       = hold_reg;
  assign rx.rx_data_valid = hold_valid_reg;
`endif
endmodule
